uncache_data_bridge: RTL and testbench
======================================

Name: uncache_data_bridge

Overview:
Downstream consumer of the data-side address translation. It takes data accesses whose physical address is flagged uncached (kseg1) and converts each into a single-beat AXI4 read or write transaction on a dedicated master port. It stalls the memory stage until the transaction completes. The data cache handles all cached traffic; this block only sees requests gated by the uncached flag.

Parameters:
AXI_ID, 4'd1, fixed arid/awid value for all transactions issued by this block
ID_W, 4, width of the AXI id fields

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
req  in  1  uncached data request (memory stage valid & no_cache_d)
wr  in  1  1=store, 0=load
size  in  2  0=byte, 1=half, 2=word
addr  in  32  physical address (already translated)
wdata  in  32  store data, lane-aligned
wstrb  in  4  store byte enables
addr_ok  out  1  request accepted this cycle
data_ok  out  1  one-cycle completion pulse
rdata  out  32  load data, valid when data_ok & ~wr
stall  out  1  pipeline stall: request pending and not yet data_ok
arid/araddr/arlen/arsize/arburst/arvalid  out  ID_W/32/8/3/2/1  AXI read address channel
arready  in  1
rid/rdata_m/rresp/rlast/rvalid  in  ID_W/32/2/1/1  AXI read data channel
rready  out  1
awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_W/32/8/3/2/1  AXI write address channel
awready  in  1
wdata_m/wstrb_m/wlast/wvalid  out  32/4/1/1  AXI write data channel
wready  in  1
bresp/bvalid  in  2/1
bready  out  1

Behaviour:
- Reset (resetn=0, async): FSM=IDLE; every valid/ready output = 0; addr_ok=0; data_ok=0; rdata=0; stall=0; latched request registers = 0. Reset mid-transaction drops the transaction with no completion pulse.
- FSM states and transitions:
  - IDLE: req=1 -> addr_ok=1 (combinational) and the request is latched. Load -> RD_ADDR; store -> WR.
  - RD_ADDR: arvalid=1 until arready, then -> RD_DATA.
  - RD_DATA: rready=1. On rvalid&rlast, capture rdata_m and go to DONE.
  - WR: awvalid and wvalid are raised together and drop independently on their handshakes, tracked by aw_done and w_done flags. Either order and same-cycle handshakes are legal. When both are done -> WR_RESP.
  - WR_RESP: bready=1. On bvalid -> DONE.
  - DONE: data_ok=1 for exactly one cycle; rdata holds the captured value. Next state is IDLE.
- Latency: a read handshake at cycle N gives data_ok and rdata at cycle N+1. A b handshake at cycle N gives data_ok at N+1.
- A new request can be accepted no earlier than the cycle after data_ok.
- stall = req & ~data_ok, so it is 1 through the accept cycle and every wait cycle.
- Fixed AXI fields: arlen=awlen=0; burst=INCR (2'b01); wlast=1; arid=awid=AXI_ID.
- arsize/awsize = {1'b0,size}. araddr/awaddr = the latched addr unmodified, so sub-word addresses are kept.
- wstrb_m = latched wstrb. wdata_m = latched wdata.
- rdata is returned raw 32-bit. Lane extraction and sign extension stay in the memory stage.
- rresp/bresp errors are ignored: the transaction completes normally. rid is not checked.
- While the FSM is not IDLE, req is ignored and the latched fields do not change.
- AXI outputs stay stable while valid is high and ready is low.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE);
  - AXI constants BURST_INCR=2'b01 and LEN_SINGLE=8'd0;
  - a typedef for the latched request (wr, size, addr, wdata, wstrb).
- No sub-module: a single FSM plus request latch. The two-flag AW/W tracker stays inline.

Test Plan:
- Uncached load, addr=0x1FAF_F000, size=2. arready held 0 for 3 cycles, then rvalid with rdata_m=0x1234_5678 -> araddr=0x1FAF_F000 and arsize=3'b010; data_ok pulses once the cycle after the r handshake; rdata=0x1234_5678; stall=1 from accept until the pulse.
- Byte store, addr=0x1FAF_F001, size=0, wstrb=4'b0010, wdata=0x0000_AB00. wready fires 2 cycles before awready -> awsize=0, wstrb_m=0010, wlast=1; wvalid drops after its handshake while awvalid stays high; data_ok one cycle after bvalid.
- Store with awready and wready both fired in the same cycle as awvalid is raised -> goes straight to WR_RESP; no duplicate aw or w beat.
- Load request held high through completion, then a second load -> the second addr_ok appears no earlier than the cycle after the first data_ok; exactly two ar transactions are issued.
- resetn asserted while in RD_DATA -> all valid/ready outputs and data_ok go 0 immediately; after release the FSM is IDLE; no spurious data_ok.
- bresp=2'b10 (SLVERR) on a store -> the transaction still completes with a single data_ok pulse.

Source files
------------

// File: rtl/uncache_data_bridge_pkg.sv
// uncache_data_bridge_pkg
//   Shared types and constants for the uncached data bridge.
//   Holds the bridge FSM state encoding, the fixed single-beat AXI burst
//   fields, and the packed record used to hold an accepted request.
package uncache_data_bridge_pkg;

  // Bridge FSM states
  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    WR_RESP,
    DONE
  } state_t;

  // Every transaction is a single INCR beat
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  // Request fields captured on acceptance and held until completion
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

endpackage

// File: rtl/uncache_data_bridge.sv
// uncache_data_bridge
//   Turns one uncached (kseg1) data access from the memory stage into a
//   single-beat AXI4 read or write, stalling the pipeline until it finishes.
//
// Ports:
//   clk, resetn              core clock, asynchronous active-low reset
//   req/wr/size/addr/        request side: accepted with addr_ok, finished
//   wdata/wstrb              with a one-cycle data_ok pulse; rdata holds
//   addr_ok/data_ok/rdata    the raw 32-bit load word; stall holds the
//   stall                    pipeline while the access is outstanding
//   ar*/r*                   AXI read address / read data channels
//   aw*/w*/b*                AXI write address / write data / response
module uncache_data_bridge
  import uncache_data_bridge_pkg::*;
#(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = ID_W'(1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req,
  input  logic            wr,
  input  logic [1:0]      size,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  output logic            addr_ok,
  output logic            data_ok,
  output logic [31:0]     rdata,
  output logic            stall,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata_m,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata_m,
  output logic [3:0]      wstrb_m,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  state_t state, state_nxt;
  req_t   lat;
  logic   aw_done, w_done;
  logic   aw_fin, w_fin;

  // Response codes and ids are deliberately ignored; the stored wr bit is
  // only informative since the state already encodes direction.
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, bresp, lat.wr};

  // A write channel counts as finished once its flag is set or it is
  // handshaking right now, so same-cycle AW/W completion is covered.
  assign aw_fin = aw_done | (awvalid & awready);
  assign w_fin  = w_done  | (wvalid  & wready);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req)             state_nxt = wr ? WR : RD_ADDR;
      RD_ADDR: if (arready)         state_nxt = RD_DATA;
      RD_DATA: if (rvalid && rlast) state_nxt = DONE;
      WR:      if (aw_fin && w_fin) state_nxt = WR_RESP;
      WR_RESP: if (bvalid)          state_nxt = DONE;
      DONE:                         state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state. addr_ok and stall follow req
  // combinationally, so they are gated by resetn to stay low during reset.
  always_comb begin
    addr_ok = 1'b0;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    data_ok = 1'b0;
    unique case (state)
      IDLE:    addr_ok = req & resetn;
      RD_ADDR: arvalid = 1'b1;
      RD_DATA: rready  = 1'b1;
      WR: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
      end
      WR_RESP: bready  = 1'b1;
      DONE:    data_ok = 1'b1;
      default: ;
    endcase
    stall = req & ~data_ok & resetn;
  end

  // Request latch: only loaded on acceptance, so fields stay frozen for
  // the whole transaction and the AXI payload is stable under backpressure.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat <= '0;
    end else if (state == IDLE && req) begin
      lat <= '{wr: wr, size: size, addr: addr, wdata: wdata, wstrb: wstrb};
    end
  end

  // AW/W completion flags, cleared while idle so each store starts fresh
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == IDLE) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == WR) begin
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
    end
  end

  // Load data capture; the value is held after the data_ok pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (state == RD_DATA && rvalid && rlast) begin
      rdata <= rdata_m;
    end
  end

  assign arid    = AXI_ID;
  assign araddr  = lat.addr;
  assign arlen   = LEN_SINGLE;
  assign arsize  = {1'b0, lat.size};
  assign arburst = BURST_INCR;

  assign awid    = AXI_ID;
  assign awaddr  = lat.addr;
  assign awlen   = LEN_SINGLE;
  assign awsize  = {1'b0, lat.size};
  assign awburst = BURST_INCR;

  assign wdata_m = lat.wdata;
  assign wstrb_m = lat.wstrb;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_uncache_data_bridge.sv
// tb_uncache_data_bridge
//   Directed bench for uncache_data_bridge. A transaction-phase model
//   predicts every output each cycle; directed sequences add literal checks.
module tb_uncache_data_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        addr_ok, data_ok, stall;
  logic [31:0] rdata;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, rready, awvalid, wvalid, bready, wlast;
  logic        arready = 1'b0;
  logic [3:0]  rid = 4'd1;
  logic [31:0] rdata_m = '0;
  logic [1:0]  rresp = 2'd0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        awready = 1'b0;
  logic [31:0] wdata_m;
  logic [3:0]  wstrb_m;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'd0;
  logic        bvalid = 1'b0;

  int check_cnt = 0;
  int err_cnt   = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, ok_cnt = 0;

  always #5 clk = ~clk;

  uncache_data_bridge #(.ID_W(4), .AXI_ID(4'd1)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata), .wstrb(wstrb), .addr_ok(addr_ok),
    .data_ok(data_ok), .rdata(rdata), .stall(stall),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata_m(rdata_m), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata_m(wdata_m), .wstrb_m(wstrb_m), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Transaction-phase model: an accepted access owes a list of channel
  // beats (AR then R, or AW and W then B); once the last one is seen the
  // access reports done for one cycle and the bridge is free again.
  logic        m_busy = 1'b0, m_done = 1'b0, m_wr = 1'b0;
  logic        m_need_ar = 1'b0, m_need_aw = 1'b0, m_need_w = 1'b0;
  logic [1:0]  m_size = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [3:0]  m_wstrb = '0;

  function automatic logic e_arvalid(); return m_busy & ~m_wr & m_need_ar; endfunction
  function automatic logic e_rready();  return m_busy & ~m_wr & ~m_need_ar; endfunction
  function automatic logic e_awvalid(); return m_busy & m_wr & m_need_aw; endfunction
  function automatic logic e_wvalid();  return m_busy & m_wr & m_need_w; endfunction
  function automatic logic e_bready();  return m_busy & m_wr & ~m_need_aw & ~m_need_w; endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_wr <= 1'b0;
      m_need_ar <= 1'b0; m_need_aw <= 1'b0; m_need_w <= 1'b0;
      m_size <= '0; m_addr <= '0; m_wdata <= '0; m_wstrb <= '0; m_rdata <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (!m_busy) begin
      if (req) begin
        m_busy <= 1'b1; m_wr <= wr; m_size <= size; m_addr <= addr;
        m_wdata <= wdata; m_wstrb <= wstrb;
        m_need_ar <= ~wr; m_need_aw <= wr; m_need_w <= wr;
      end
    end else if (!m_wr) begin
      if (e_arvalid() && arready) m_need_ar <= 1'b0;
      if (e_rready() && rvalid && rlast) begin
        m_rdata <= rdata_m; m_busy <= 1'b0; m_done <= 1'b1;
      end
    end else begin
      if (e_awvalid() && awready) m_need_aw <= 1'b0;
      if (e_wvalid() && wready)   m_need_w  <= 1'b0;
      if (e_bready() && bvalid) begin
        m_busy <= 1'b0; m_done <= 1'b1;
      end
    end
  end

  // Handshake counters used by the directed sequences
  always @(posedge clk) begin
    if (arvalid && arready) ar_cnt <= ar_cnt + 1;
    if (awvalid && awready) aw_cnt <= aw_cnt + 1;
    if (wvalid && wready)   w_cnt  <= w_cnt + 1;
    if (data_ok)            ok_cnt <= ok_cnt + 1;
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      check_output("addr_ok", addr_ok, resetn & ~m_busy & ~m_done & req);
      check_output("data_ok", data_ok, m_done);
      check_output("stall", stall, resetn & req & ~m_done);
      check_output("rdata", rdata, m_rdata);
      check_output("arvalid", arvalid, e_arvalid());
      check_output("rready", rready, e_rready());
      check_output("awvalid", awvalid, e_awvalid());
      check_output("wvalid", wvalid, e_wvalid());
      check_output("bready", bready, e_bready());
      if (arvalid) begin
        check_output("araddr", araddr, m_addr);
        check_output("ar_fixed", {arid, arlen, arsize, arburst},
                     {4'd1, 8'd0, 1'b0, m_size, 2'b01});
      end
      if (awvalid) begin
        check_output("awaddr", awaddr, m_addr);
        check_output("aw_fixed", {awid, awlen, awsize, awburst},
                     {4'd1, 8'd0, 1'b0, m_size, 2'b01});
      end
      if (wvalid) begin
        check_output("wdata_m", wdata_m, m_wdata);
        check_output("w_fixed", {wstrb_m, wlast}, {m_wstrb, 1'b1});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic w, input logic [1:0] s,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] b);
    req = 1'b1; wr = w; size = s; addr = a; wdata = d; wstrb = b;
  endtask

  initial begin
    int base_ar, base_aw, base_w, base_ok;
    int first_ok, acc0, acc1;

    // Reset: req high must not leak through addr_ok or stall
    req = 1'b1;
    repeat (3) tick();
    check_output("rst_addr_ok", addr_ok, 1'b0);
    check_output("rst_stall", stall, 1'b0);
    check_output("rst_data_ok", data_ok, 1'b0);
    check_output("rst_rdata", rdata, 32'h0);
    req = 1'b0;
    resetn = 1'b1;
    tick();

    // Word load with AR backpressure
    apply_stimulus(1'b0, 2'd2, 32'h1FAF_F000, 32'h0, 4'h0);
    #1 check_output("t1_addr_ok", addr_ok, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_output("t1_araddr", araddr, 32'h1FAF_F000);
      check_output("t1_arsize", arsize, 3'b010);
      check_output("t1_stall", stall, 1'b1);
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata_m = 32'h1234_5678;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    check_output("t1_data_ok", data_ok, 1'b1);
    check_output("t1_rdata", rdata, 32'h1234_5678);
    req = 1'b0;
    tick();
    check_output("t1_data_ok_end", data_ok, 1'b0);
    check_output("t1_rdata_hold", rdata, 32'h1234_5678);

    // Byte store, W accepted two cycles before AW
    apply_stimulus(1'b1, 2'd0, 32'h1FAF_F001, 32'h0000_AB00, 4'b0010);
    tick();
    wready = 1'b1;
    #1 check_output("t2_awsize", awsize, 3'b000);
    check_output("t2_wstrb_m", wstrb_m, 4'b0010);
    check_output("t2_wlast", wlast, 1'b1);
    tick();
    wready = 1'b0;
    check_output("t2_wvalid_drop", wvalid, 1'b0);
    check_output("t2_awvalid_hold", awvalid, 1'b1);
    tick();
    awready = 1'b1;
    tick();
    awready = 1'b0; bvalid = 1'b1;
    check_output("t2_bready", bready, 1'b1);
    tick();
    bvalid = 1'b0;
    check_output("t2_data_ok", data_ok, 1'b1);
    req = 1'b0;
    tick();

    // Store with AW and W both ready as soon as they are raised
    base_aw = aw_cnt; base_w = w_cnt;
    apply_stimulus(1'b1, 2'd2, 32'h1FAF_F008, 32'hDEAD_BEEF, 4'hF);
    awready = 1'b1; wready = 1'b1;
    tick();
    check_output("t3_both_valid", {awvalid, wvalid}, 2'b11);
    tick();
    awready = 1'b0; wready = 1'b0;
    check_output("t3_to_resp", {awvalid, wvalid, bready}, 3'b001);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0; req = 1'b0;
    tick();
    check_output("t3_aw_beats", aw_cnt - base_aw, 1);
    check_output("t3_w_beats", w_cnt - base_w, 1);

    // Two back-to-back loads with req held high throughout
    base_ar = ar_cnt;
    first_ok = -1; acc0 = -1; acc1 = -1;
    apply_stimulus(1'b0, 2'd2, 32'h1FAF_F010, 32'h0, 4'h0);
    arready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rdata_m = 32'hCAFE_F00D;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (data_ok && first_ok < 0) first_ok = c;
      if (addr_ok) begin
        if (acc0 < 0) acc0 = c;
        else if (acc1 < 0) acc1 = c;
      end
      if (c == 7) req = 1'b0;
      tick();
      if (c == 0) addr = 32'h1FAF_F014;
    end
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    check_output("t4_first_ok", first_ok, 3);
    check_output("t4_second_acc", acc1, 4);
    check_output("t4_ar_beats", ar_cnt - base_ar, 2);

    // Reset while waiting for read data
    apply_stimulus(1'b0, 2'd2, 32'h1FAF_F020, 32'h0, 4'h0);
    arready = 1'b1;
    tick();
    tick();
    arready = 1'b0;
    tick();
    base_ok = ok_cnt;
    resetn = 1'b0;
    #1 check_output("t5_rready", rready, 1'b0);
    check_output("t5_valids", {arvalid, awvalid, wvalid, bready}, 4'b0000);
    check_output("t5_data_ok", data_ok, 1'b0);
    check_output("t5_addr_ok", addr_ok, 1'b0);
    check_output("t5_rdata", rdata, 32'h0);
    req = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    check_output("t5_no_pulse", ok_cnt - base_ok, 0);
    req = 1'b1; wr = 1'b0;
    #1 check_output("t5_idle", addr_ok, 1'b1);
    req = 1'b0;
    tick();

    // SLVERR write response still completes with one pulse
    base_ok = ok_cnt;
    apply_stimulus(1'b1, 2'd1, 32'h1FAF_F032, 32'h5A5A_0000, 4'b1100);
    awready = 1'b1; wready = 1'b1;
    tick();
    tick();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    check_output("t6_data_ok", data_ok, 1'b1);
    req = 1'b0;
    tick();
    check_output("t6_single_pulse", ok_cnt - base_ok, 1);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
